// File: rtl/hazard_detection_unit_if.sv
// Hazard detection bundle: ID/EX/MEM register fields and load/write flags in,
// stall controls (Check, PCWrite, IFIDWrite) and the stall-cycle count out.
interface hazard_detection_unit_if;
    logic [4:0]  IFID_Rs;
    logic [4:0]  IFID_Rt;
    logic        IFID_UsesRt;
    logic        IFID_BranchOrJr;
    logic [4:0]  IDEX_WriteReg;
    logic        IDEX_MemRead;
    logic        IDEX_RegWrite;
    logic [4:0]  EXMEM_WriteReg;
    logic        EXMEM_MemRead;
    logic        Flush;
    logic        Check;
    logic        PCWrite;
    logic        IFIDWrite;
    logic [31:0] StallCycles;

    modport master (
        output IFID_Rs, IFID_Rt, IFID_UsesRt, IFID_BranchOrJr,
        output IDEX_WriteReg, IDEX_MemRead, IDEX_RegWrite,
        output EXMEM_WriteReg, EXMEM_MemRead, Flush,
        input  Check, PCWrite, IFIDWrite, StallCycles
    );

    modport slave (
        input  IFID_Rs, IFID_Rt, IFID_UsesRt, IFID_BranchOrJr,
        input  IDEX_WriteReg, IDEX_MemRead, IDEX_RegWrite,
        input  EXMEM_WriteReg, EXMEM_MemRead, Flush,
        output Check, PCWrite, IFIDWrite, StallCycles
    );
endinterface

// File: rtl/hazard_detection_unit.sv
// Hazard detection unit: load-use and branch-operand stalls, two-state FSM
// holding the second cycle of a branch-after-load stall.
// Ports: Clk, Rst (sync, active high), hdu (hazard_detection_unit_if.slave).
// Macro HDU_STALL_COUNTER_EN enables the saturating StallCycles counter;
// without it StallCycles is tied to zero.
module hazard_detection_unit (
    input  logic Clk,
    input  logic Rst,
    hazard_detection_unit_if.slave hdu
);
    typedef enum logic {IDLE, HOLD} state_t;

    state_t state;
    logic   exMatch;
    logic   memMatch;
    logic   hLu;
    logic   hBa;
    logic   hBl;
    logic   hBm;
    logic   stall;

    function automatic logic regMatch(
        input logic [4:0] r,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       usesRt
    );
        return (r != 5'd0) &&
               ((r == rs) || (usesRt && (r == rt)));
    endfunction

    always_comb begin
        exMatch  = regMatch(hdu.IDEX_WriteReg, hdu.IFID_Rs,
                            hdu.IFID_Rt, hdu.IFID_UsesRt);
        memMatch = regMatch(hdu.EXMEM_WriteReg, hdu.IFID_Rs,
                            hdu.IFID_Rt, hdu.IFID_UsesRt);
        hLu = hdu.IDEX_MemRead && exMatch;
        hBa = hdu.IFID_BranchOrJr && hdu.IDEX_RegWrite &&
              !hdu.IDEX_MemRead && exMatch;
        hBl = hdu.IFID_BranchOrJr && hdu.IDEX_MemRead && exMatch;
        hBm = hdu.IFID_BranchOrJr && hdu.EXMEM_MemRead && memMatch;
    end

    // Reset and Flush both dominate; HOLD stalls without looking at inputs.
    always_comb begin
        stall = 1'b0;
        if (Rst || hdu.Flush)
            stall = 1'b0;
        else if (state == HOLD)
            stall = 1'b1;
        else
            stall = hLu || hBa || hBl || hBm;
    end

    assign hdu.Check     = stall;
    assign hdu.PCWrite   = !stall;
    assign hdu.IFIDWrite = !stall;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
        end else if (hdu.Flush) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE:    state <= hBl ? HOLD : IDLE;
                HOLD:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef HDU_STALL_COUNTER_EN
    logic [31:0] stallCount;

    always_ff @(posedge Clk) begin
        if (Rst)
            stallCount <= '0;
        else if (stall && (stallCount != 32'hFFFF_FFFF))
            stallCount <= stallCount + 32'd1;
    end

    assign hdu.StallCycles = stallCount;
`else
    assign hdu.StallCycles = '0;
`endif
endmodule

// File: tb/tb_hazard_detection_unit.sv
// Self-checking bench for hazard_detection_unit: table vectors, directed
// multi-cycle sequences and random stimulus against a stall-length model.
module tb_hazard_detection_unit;
    logic Clk = 1'b0;
    logic Rst;

    always #5 Clk = ~Clk;

    hazard_detection_unit_if hif ();

    hazard_detection_unit dut (
        .Clk (Clk),
        .Rst (Rst),
        .hdu (hif.slave)
    );

`ifdef HDU_STALL_COUNTER_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct {
        logic       rst;
        logic       flush;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       usesRt;
        logic       brj;
        logic [4:0] exWr;
        logic       exMr;
        logic       exRw;
        logic [4:0] memWr;
        logic       memMr;
    } vec_t;

    typedef struct {
        string name;
        vec_t  v;
        logic  expCheck;
    } tv_t;

    int checks = 0;
    int errors = 0;
    int pending = 0;
    longint unsigned cnt = 0;

    function automatic vec_t mk(
        input logic [4:0] rs, input logic [4:0] rt,
        input logic usesRt, input logic brj,
        input logic [4:0] exWr, input logic exMr, input logic exRw,
        input logic [4:0] memWr, input logic memMr
    );
        vec_t v;
        v.rst = 1'b0; v.flush = 1'b0;
        v.rs = rs; v.rt = rt; v.usesRt = usesRt; v.brj = brj;
        v.exWr = exWr; v.exMr = exMr; v.exRw = exRw;
        v.memWr = memWr; v.memMr = memMr;
        return v;
    endfunction

    function automatic bit reads(input vec_t v, input logic [4:0] r);
        if (r == 0) return 0;
        return (r == v.rs) || (v.usesRt && r == v.rt);
    endfunction

    // Stall length the ID instruction needs when starting from no stall.
    function automatic int needLen(input vec_t v);
        int len = 0;
        if (v.exMr && reads(v, v.exWr)) len = 1;
        if (v.brj && v.exRw && !v.exMr && reads(v, v.exWr)) len = 1;
        if (v.brj && v.memMr && reads(v, v.memWr) && len < 1) len = 1;
        if (v.brj && v.exMr && reads(v, v.exWr)) len = 2;
        return len;
    endfunction

    task automatic cmp(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        Rst = v.rst;
        hif.Flush = v.flush;
        hif.IFID_Rs = v.rs;
        hif.IFID_Rt = v.rt;
        hif.IFID_UsesRt = v.usesRt;
        hif.IFID_BranchOrJr = v.brj;
        hif.IDEX_WriteReg = v.exWr;
        hif.IDEX_MemRead = v.exMr;
        hif.IDEX_RegWrite = v.exRw;
        hif.EXMEM_WriteReg = v.memWr;
        hif.EXMEM_MemRead = v.memMr;
    endtask

    task automatic step(input string tag, input vec_t v,
                        output logic gotCheck);
        logic expChk;
        int nextPend;
        int len;
        @(negedge Clk);
        drive(v);
        #1;
        if (v.rst || v.flush) begin
            expChk = 0; nextPend = 0;
        end else if (pending > 0) begin
            expChk = 1; nextPend = pending - 1;
        end else begin
            len = needLen(v);
            expChk = (len > 0);
            nextPend = (len > 0) ? len - 1 : 0;
        end
        gotCheck = hif.Check;
        cmp({tag, ".Check"}, {31'd0, hif.Check}, {31'd0, expChk});
        cmp({tag, ".PCWrite"}, {31'd0, hif.PCWrite}, {31'd0, !expChk});
        cmp({tag, ".IFIDWrite"}, {31'd0, hif.IFIDWrite},
            {31'd0, !expChk});
        cmp({tag, ".StallCycles"}, hif.StallCycles,
            CNT_EN ? cnt[31:0] : 32'd0);
        @(posedge Clk);
        pending = nextPend;
        if (v.rst) cnt = 0;
        else if (expChk && cnt != 64'hFFFF_FFFF) cnt++;
    endtask

    tv_t  tbl[10];
    vec_t z;
    vec_t fl;
    vec_t rs;
    vec_t bl;
    vec_t r;
    logic c0, c1, c2;

    initial begin
        z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        fl = z; fl.flush = 1;
        rs = z; rs.rst = 1;
        bl = mk(8, 0, 0, 1, 8, 1, 1, 0, 0);

        tbl[0] = '{"lu_rs",      mk(8, 10, 1, 0, 8, 1, 1, 0, 0), 1};
        tbl[1] = '{"lu_rt_nouse",mk(1, 8, 0, 0, 8, 1, 1, 0, 0), 0};
        tbl[2] = '{"lu_rt_use",  mk(1, 8, 1, 0, 8, 1, 1, 0, 0), 1};
        tbl[3] = '{"lu_r0",      mk(0, 0, 1, 0, 0, 1, 1, 0, 0), 0};
        tbl[4] = '{"ba_jr",      mk(5, 0, 0, 1, 5, 0, 1, 0, 0), 1};
        tbl[5] = '{"ba_nobr",    mk(5, 0, 0, 0, 5, 0, 1, 0, 0), 0};
        tbl[6] = '{"bm_rt",      mk(1, 4, 1, 1, 0, 0, 0, 4, 1), 1};
        tbl[7] = '{"bm_nobr",    mk(1, 4, 1, 0, 0, 0, 0, 4, 1), 0};
        tbl[8] = '{"bl_rs",      mk(3, 0, 1, 1, 3, 1, 1, 0, 0), 1};
        tbl[9] = '{"flush_lu",   mk(8, 0, 0, 0, 8, 1, 1, 0, 0), 0};
        tbl[9].v.flush = 1;

        drive(rs);
        @(posedge Clk);
        step("reset", rs, c0);

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].name, tbl[i].v, c0);
            cmp({tbl[i].name, ".tbl"}, {31'd0, c0},
                {31'd0, tbl[i].expCheck});
            step("tbl_flush", fl, c1);
        end

        step("s032_rst", rs, c0);
        step("s032_lu", mk(8, 10, 1, 0, 8, 1, 1, 0, 0), c0);
        step("s032_after", mk(0, 0, 0, 0, 9, 0, 1, 8, 1), c1);
        cmp("s032_seq", {30'd0, c0, c1}, 32'b10);
        if (CNT_EN) cmp("s032_cnt", hif.StallCycles, 32'd1);

        step("s033_bl", bl, c0);
        step("s033_hold", z, c1);
        step("s033_done", z, c2);
        cmp("s033_seq", {29'd0, c0, c1, c2}, 32'b110);

        step("s034_jr", mk(5, 0, 0, 1, 5, 0, 1, 0, 0), c0);
        step("s034_r0", mk(0, 0, 0, 1, 0, 0, 1, 0, 0), c1);
        cmp("s034_seq", {30'd0, c0, c1}, 32'b10);

        r = bl; r.flush = 1;
        step("s035_bl", bl, c0);
        step("s035_flush", r, c1);
        step("s035_idle", z, c2);
        cmp("s035_seq", {29'd0, c0, c1, c2}, 32'b100);

        r = bl; r.rst = 1;
        step("s036_bl", bl, c0);
        step("s036_rst", r, c1);
        step("s036_post", z, c2);
        cmp("s036_seq", {29'd0, c0, c1, c2}, 32'b100);
        cmp("s036_cnt", hif.StallCycles, 32'd0);

        for (int i = 0; i < 400; i++) begin
            r = mk(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom), 1'($urandom),
                   5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                   5'($urandom_range(0, 3)), 1'($urandom));
            r.flush = ($urandom_range(0, 9) == 0);
            r.rst = ($urandom_range(0, 39) == 0);
            step("rand", r, c0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_detection_unit.md
HAZARD_DETECTION_UNIT -- requirements
Module: hazard_detection_unit

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: Clk and Rst.
REQ-002 Clk  input  1  rising-edge clock shared with all pipeline registers.
REQ-003 Rst  input  1  synchronous active-high reset.
REQ-004 IFID_Rs, IFID_Rt  input  5 each  source register fields of the instruction in ID.
REQ-005 IFID_UsesRt  input  1  ID instruction reads Rt (R-type, sw, beq/bne).
REQ-006 IFID_BranchOrJr  input  1  ID instruction resolves in ID (beq/bne/jr) and needs operands there.
REQ-007 IDEX_WriteReg  input  5  resolved destination register of the EX instruction.
REQ-008 IDEX_MemRead, IDEX_RegWrite  input  1 each  EX instruction is a load / writes a register.
REQ-009 EXMEM_WriteReg  input  5; EXMEM_MemRead  input  1  MEM-stage destination register and load flag.
REQ-010 Flush  input  1  taken branch/jump resolved this cycle; cancels any stall.
REQ-011 Check  output  1  1 = zero the ID control word (bubble into ID/EX).
REQ-012 PCWrite, IFIDWrite  output  1 each  0 = hold PC / hold IF/ID register.
REQ-013 StallCycles  output  32  count of cycles with Check=1.

Function
REQ-014 Match(r) SHALL be: r!=0 and (r==IFID_Rs or (IFID_UsesRt and r==IFID_Rt)).
REQ-015 H_LU (load-use) SHALL be IDEX_MemRead and Match(IDEX_WriteReg); 1 stall cycle.
REQ-016 H_BA SHALL be IFID_BranchOrJr and IDEX_RegWrite and not IDEX_MemRead and Match(IDEX_WriteReg); 1 stall cycle.
REQ-017 H_BL SHALL be IFID_BranchOrJr and IDEX_MemRead and Match(IDEX_WriteReg); 2 stall cycles.
REQ-018 H_BM SHALL be IFID_BranchOrJr and EXMEM_MemRead and Match(EXMEM_WriteReg); 1 stall cycle.
REQ-019 FSM SHALL have two states: IDLE, HOLD.
REQ-020 In IDLE: Stall = H_LU|H_BA|H_BL|H_BM, combinational, same cycle as detection (zero latency).
REQ-021 IDLE->HOLD SHALL occur on an edge where H_BL is true and Flush=0; otherwise remain IDLE.
REQ-022 In HOLD: Stall=1 regardless of hazard inputs; HOLD->IDLE unconditionally on next edge.
REQ-023 Flush=1 SHALL force Stall=0 that cycle and next state IDLE, in either state (Flush beats hazards).
REQ-024 Outputs SHALL be Check=Stall, PCWrite=~Stall, IFIDWrite=~Stall; never Check=1 with PCWrite=1.
REQ-025 Multiple simultaneous hazards SHALL produce one stall of the longest required length (H_BL wins).
REQ-026 Register 0 SHALL never cause a hazard.

Reset
REQ-027 Rst=1 at an edge SHALL set state IDLE and StallCycles=0, overriding Flush and hazards.
REQ-028 While Rst=1, outputs SHALL be Check=0, PCWrite=1, IFIDWrite=1.
REQ-029 Rst asserted in HOLD SHALL abort the pending stall; first post-reset cycle evaluates from IDLE.

Configuration
REQ-030 Macro HDU_STALL_COUNTER_EN defined: StallCycles SHALL increment by 1 each non-reset edge where Check=1, saturating at 0xFFFFFFFF.
REQ-031 Macro undefined: StallCycles port SHALL remain present, tied to 0, no counter flops; all other behaviour identical.

Verification
REQ-032 lw $8 in EX (IDEX_MemRead=1, WriteReg=8), add $9,$8,$10 in ID -> Check=1, PCWrite=0 for exactly 1 cycle; StallCycles 0->1.
REQ-033 lw $8 in EX, beq $8,$0 in ID (BranchOrJr=1) -> Check=1 for 2 consecutive cycles (IDLE, HOLD), then 0.
REQ-034 add $5 in EX (RegWrite=1), jr $5 in ID -> 1-cycle stall; same with IDEX_WriteReg=0 and IFID_Rs=0 -> no stall.
REQ-035 H_BL detected, Flush=1 on the HOLD cycle -> Check=0 that cycle, state IDLE next cycle.
REQ-036 Rst=1 during HOLD -> next cycle Check=0, PCWrite=1, StallCycles=0; with macro, force counter to 0xFFFFFFFF and stall -> value holds.
